// File: rtl/uart_frac_baud_gen.sv
// Fractional baud generator: oversample/mid-bit/bit ticks, registered, first os_tick D cycles after load.
// No backpressure: enable low freezes all state, load restarts generation from phase 0.
`timescale 1ns/1ps
module uart_frac_baud_gen #(
    parameter int INT_W     = 16,
    parameter int FRAC_W    = 4,
    parameter int OSR       = 16,
    parameter int RESET_DIV = 27
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [INT_W-1:0]        divisor_int,
    input  logic [FRAC_W-1:0]       divisor_frac,
    output logic                    os_tick,
    output logic                    mid_tick,
    output logic                    bit_tick,
    output logic [$clog2(OSR)-1:0]  os_phase,
    output logic                    cfg_err
);

    localparam int PH_W = $clog2(OSR);
    localparam logic [PH_W-1:0] MID_LAST = PH_W'(OSR / 2 - 1);
    localparam logic [PH_W-1:0] BIT_LAST = PH_W'(OSR - 1);

    logic [INT_W-1:0]  div_int_q;
    logic [FRAC_W-1:0] div_frac_q;
    logic [INT_W:0]    cnt;
    logic [FRAC_W-1:0] acc;
    logic              carry_q;
    logic [PH_W-1:0]   os_cnt;

    logic [INT_W:0]    period;
    logic [INT_W:0]    last_cnt;
    logic              boundary;
    logic [FRAC_W:0]   acc_sum;

    // One extra period bit so the maximum divisor plus a dither carry cannot wrap.
    always_comb begin
        period   = {1'b0, div_int_q} + {{INT_W{1'b0}}, carry_q};
        last_cnt = period - 1'b1;
        boundary = (cnt == last_cnt);
        acc_sum  = {1'b0, acc} + {1'b0, div_frac_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_int_q  <= INT_W'(RESET_DIV);
            div_frac_q <= '0;
            cnt        <= '0;
            acc        <= '0;
            carry_q    <= 1'b0;
            os_cnt     <= '0;
            os_tick    <= 1'b0;
            mid_tick   <= 1'b0;
            bit_tick   <= 1'b0;
            cfg_err    <= (RESET_DIV == 0);
        end else if (load) begin
            div_int_q  <= divisor_int;
            div_frac_q <= divisor_frac;
            cnt        <= '0;
            acc        <= '0;
            carry_q    <= 1'b0;
            os_cnt     <= '0;
            os_tick    <= 1'b0;
            mid_tick   <= 1'b0;
            bit_tick   <= 1'b0;
            cfg_err    <= (divisor_int == '0);
        end else if (enable && !cfg_err) begin
            if (boundary) begin
                cnt      <= '0;
                os_tick  <= 1'b1;
                {carry_q, acc} <= acc_sum;
                os_cnt   <= os_cnt + 1'b1;
                mid_tick <= (os_cnt == MID_LAST);
                bit_tick <= (os_cnt == BIT_LAST);
            end else begin
                cnt      <= cnt + 1'b1;
                os_tick  <= 1'b0;
                mid_tick <= 1'b0;
                bit_tick <= 1'b0;
            end
        end else begin
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end
    end

    assign os_phase = os_cnt;

endmodule
